// File: rtl/rt_pkg.sv
// Shared types and header field layout for the framebuffer packet writer
// and its address-generation helpers.
package rt_pkg;

    typedef enum logic [1:0] {
        PKT_NONE   = 2'b00,
        PKT_PIXELS = 2'b01,
        PKT_FILL   = 2'b10,
        PKT_RSVD   = 2'b11
    } pkt_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_COLOR,
        ST_STREAM,
        ST_FILL
    } fbw_state_t;

    // Type sits in the top TYPE_W bits of header word 0; length and start
    // address are right-aligned in words 0 and 1 respectively.
    localparam int TYPE_W   = 2;
    localparam int LEN_LSB  = 0;
    localparam int ADDR_LSB = 0;

    function automatic logic is_valid_type(input pkt_type_t t);
        return (t == PKT_PIXELS) || (t == PKT_FILL);
    endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Framebuffer address counter with load and modulo-FB_DEPTH increment;
// FB_DEPTH need not be a power of two.
module fb_addr_counter #(
    parameter int ADDR_W   = 17,
    parameter int FB_DEPTH = 76800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load)
            addr_d = load_val;
        else if (inc)
            addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    assign addr = addr_q;

endmodule

// File: rtl/fb_packet_writer.sv
// Parses PIXELS / FILL packets from a first-word-fall-through FIFO and
// drives a registered framebuffer write port, one pixel per clock.
module fb_packet_writer
    import rt_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 17,
    parameter int FB_DEPTH = 76800,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_re,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              busy,
    output logic              pkt_done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FB_DEPTH);

    fbw_state_t        state_q, state_d;
    pkt_type_t         type_q, type_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ld, inc;
    logic [ADDR_W-1:0] addr;

    fb_addr_counter #(.ADDR_W(ADDR_W), .FB_DEPTH(FB_DEPTH)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (fifo_dout[ADDR_LSB +: ADDR_W]),
        .inc      (inc),
        .addr     (addr)
    );

    // Gated by rst so the port reads 0 while reset is held with data queued.
    assign fifo_re = !rst && !fifo_empty &&
                     (state_q inside {ST_IDLE, ST_HDR_ADDR, ST_COLOR, ST_STREAM});

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        color_d = color_q;
        err_d   = err_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ld      = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: if (fifo_re) begin
                type_d = pkt_type_t'(fifo_dout[DATA_W-1 -: TYPE_W]);
                cnt_d  = fifo_dout[LEN_LSB +: LEN_W];
                drop_d = 1'b0;
                if (is_valid_type(type_d)) begin
                    state_d = ST_HDR_ADDR;
                end else begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_HDR_ADDR: if (fifo_re) begin
                ld = 1'b1;
                if ({1'b0, fifo_dout[ADDR_LSB +: ADDR_W]} >= DEPTH_C) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end
                state_d = (type_q == PKT_PIXELS) ? ST_STREAM : ST_COLOR;
            end
            ST_COLOR: if (fifo_re) begin
                color_d = fifo_dout;
                state_d = ST_FILL;
            end
            ST_STREAM, ST_FILL: if (fifo_re || state_q == ST_FILL) begin
                // Dropped packets still walk the count so framing stays intact.
                we_d    = !drop_q;
                waddr_d = addr;
                wdata_d = (state_q == ST_FILL) ? color_q : fifo_dout;
                inc     = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= PKT_NONE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            color_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            color_q <= color_d;
            err_q   <= err_d;
            we_q    <= we_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign fb_we    = we_q;
    assign fb_addr  = waddr_q;
    assign fb_wdata = wdata_q;
    assign pkt_done = done_q;
    assign err      = err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fb_packet_writer.sv
// Directed bench for fb_packet_writer: FIFO model, write/pop monitor and
// hand-computed expectations per packet scenario.
module tb_fb_packet_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_re;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [31:0] fb_wdata;
    logic        busy, pkt_done, err;

    fb_packet_writer dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .busy(busy), .pkt_done(pkt_done), .err(err)
    );

    always #5 clk = ~clk;

    // FIFO model: bench pushes, DUT pops.
    logic [31:0] mem [0:127];
    int rd = 0, wr = 0;
    logic hold = 1'b0, flush = 1'b0;
    assign fifo_empty = (rd == wr) || hold;
    assign fifo_dout  = mem[rd[6:0]];
    always @(posedge clk) begin
        if (flush)        rd <= wr;
        else if (fifo_re) rd <= rd + 1;
    end

    // Monitor
    int cyc = 0, npop = 0, nw = 0, ndone = 0, re_bad = 0;
    int pop_cyc [0:127];
    int wcyc [0:63];
    logic [16:0] wa [0:63];
    logic [31:0] wd [0:63];
    logic wdone [0:63];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fifo_re) begin
            pop_cyc[npop[6:0]] <= cyc;
            npop <= npop + 1;
            if (fifo_empty) re_bad <= re_bad + 1;
        end
        if (fb_we) begin
            wa[nw[5:0]] <= fb_addr;
            wd[nw[5:0]] <= fb_wdata;
            wdone[nw[5:0]] <= pkt_done;
            wcyc[nw[5:0]] <= cyc;
            nw <= nw + 1;
        end
        if (pkt_done) ndone <= ndone + 1;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr[6:0]] = w;
        wr = wr + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bw, bp, bd;
    logic [31:0] pix [0:3];

    initial begin
        pix[0] = 32'hA0A0_0001; pix[1] = 32'hB0B0_0002;
        pix[2] = 32'hC0C0_0003; pix[3] = 32'hD0D0_0004;

        // Reset state with the first packet already queued
        push(32'h4000_0003); push(32'd10);
        for (int i = 0; i < 4; i++) push(pix[i]);
        tick(2);
        chk("rst_fifo_re", fifo_re, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;

        // PIXELS run of 4 at address 10
        bw = nw; bd = ndone;
        tick(12);
        chk("px_nwr", nw - bw, 4);
        for (int i = 0; i < 4; i++) begin
            chk("px_addr", wa[bw+i], 10 + i);
            chk("px_data", wd[bw+i], pix[i]);
            chk("px_done", wdone[bw+i], (i == 3));
        end
        chk("px_consec", wcyc[bw+3] - wcyc[bw], 3);
        chk("px_ndone", ndone - bd, 1);
        chk("px_busy", busy, 0);
        chk("px_err", err, 0);

        // FILL of 5 wrapping across the end of the framebuffer
        bw = nw; bp = npop; bd = ndone;
        push(32'h8000_0004); push(32'd76798); push(32'h00FF_00FF);
        tick(14);
        chk("fill_nwr", nw - bw, 5);
        chk("fill_a0", wa[bw+0], 76798);
        chk("fill_a1", wa[bw+1], 76799);
        chk("fill_a2", wa[bw+2], 0);
        chk("fill_a3", wa[bw+3], 1);
        chk("fill_a4", wa[bw+4], 2);
        for (int i = 0; i < 5; i++) chk("fill_data", wd[bw+i], 32'h00FF_00FF);
        chk("fill_done", wdone[bw+4], 1);
        chk("fill_pops", npop - bp, 3);
        chk("fill_ndone", ndone - bd, 1);

        // PIXELS of 3 with the FIFO stalling every other cycle
        bw = nw; bp = npop;
        hold = 1'b1;
        push(32'h4000_0002); push(32'd100);
        push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1 hold = ~hold;
        end
        hold = 1'b0;
        tick(5);
        chk("stall_nwr", nw - bw, 3);
        chk("stall_pops", npop - bp, 5);
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", wa[bw+i], 100 + i);
            chk("stall_lat", wcyc[bw+i] - pop_cyc[bp+2+i], 1);
        end
        chk("stall_d2", wd[bw+2], 32'h3333_3333);
        chk("stall_err", err, 0);

        // Reserved header, then a single-pixel packet
        bw = nw; bp = npop; bd = ndone;
        push(32'hC000_0000);
        tick(2);
        chk("rsv_err", err, 1);
        chk("rsv_busy", busy, 0);
        push(32'h4000_0000); push(32'd5); push(32'h1234_5678);
        tick(8);
        chk("rsv_nwr", nw - bw, 1);
        chk("rsv_addr", wa[bw], 5);
        chk("rsv_data", wd[bw], 32'h1234_5678);
        chk("rsv_ndone", ndone - bd, 2);
        chk("rsv_pops", npop - bp, 4);

        // Reset mid-stream after 2 of 5 writes
        bw = nw;
        push(32'h4000_0004); push(32'd200);
        for (int i = 0; i < 5; i++) push(32'h5000_0000 + i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (nw - bw >= 2) break;
        end
        rst = 1'b1;
        #1;
        chk("mid_we", fb_we, 0);
        chk("mid_addr", fb_addr, 0);
        chk("mid_wdata", fb_wdata, 0);
        chk("mid_busy", busy, 0);
        chk("mid_re", fifo_re, 0);
        chk("mid_err", err, 0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk); rst = 1'b0;
        bp = npop;
        tick(8);
        chk("mid_nwr", nw - bw, 2);
        chk("mid_busy2", busy, 0);
        chk("mid_pops", npop - bp, 0);

        // Out-of-range start: payload consumed, writes suppressed
        bw = nw; bp = npop; bd = ndone;
        push(32'h4000_0001); push(32'd80000); push(32'h0000_0011); push(32'h0000_0022);
        push(32'h4000_0000); push(32'd7); push(32'h0000_BEEF);
        tick(14);
        chk("oor_err", err, 1);
        chk("oor_pops", npop - bp, 7);
        chk("oor_nwr", nw - bw, 1);
        chk("oor_addr", wa[bw], 7);
        chk("oor_data", wd[bw], 32'h0000_BEEF);
        chk("oor_ndone", ndone - bd, 2);
        chk("oor_busy", busy, 0);

        chk("re_while_empty", re_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_packet_writer.md
Name: fb_packet_writer

Overview:
- Parametrised successor to the ray-tracer packet controller.
- Consumes header + payload packets from the interface FIFO (first-word-fall-through) and writes pixels into the framebuffer write port.
- Supports two packet kinds: streamed pixel runs, and constant-colour fills of a region.
- Adds length counting, address generation with framebuffer wrap-around, stall handling, and error flagging.

Parameters:
- DATA_W, 32, FIFO word and pixel width (min 32).
- ADDR_W, 17, framebuffer address width.
- FB_DEPTH, 76800, number of framebuffer pixels; must be ≤ 2**ADDR_W.
- LEN_W, 16, run-length field width; must be ≤ DATA_W-2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_dout  in  DATA_W  FIFO head word, valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_re  out  1  pop head word (combinational).
- fb_we  out  1  framebuffer write strobe (registered).
- fb_addr  out  ADDR_W  write address (registered).
- fb_wdata  out  DATA_W  write data (registered).
- busy  out  1  high whenever state != IDLE.
- pkt_done  out  1  one-cycle pulse when a packet's final word or write completes.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: state=IDLE. fifo_re, fb_we, pkt_done and err are 0. fb_addr and fb_wdata are 0. Internal counters are 0.
- Header word 0 fields:
  - [DATA_W-1:DATA_W-2] = type: 01 PIXELS, 10 FILL, 00/11 reserved.
  - [LEN_W-1:0] = count-1, so 1..2**LEN_W pixels.
- Header word 1: [ADDR_W-1:0] = start address.
- FILL packets carry exactly one payload word (the colour). PIXELS packets carry count payload words.
- fifo_re = !fifo_empty && state in {IDLE, HDR_ADDR, COLOR, STREAM}. fifo_re is never asserted while fifo_empty=1.
- FSM transitions:
  - IDLE: on pop, latch type and count.
    - Type 01 or 10 → HDR_ADDR.
    - Reserved type → err=1, pkt_done pulse, stay IDLE (header discarded).
  - HDR_ADDR: on pop, latch start into addr_q.
    - If start ≥ FB_DEPTH: set err=1 and set a drop flag (all writes suppressed for this packet, payload still consumed).
    - PIXELS → STREAM. FILL → COLOR.
  - STREAM: each pop issues one write.
    - Next cycle: fb_we=1 (unless dropping), fb_wdata=popped word, fb_addr=addr_q.
    - Then addr_q advances, and remaining count decrements.
    - The pop of the last word → IDLE, with pkt_done asserted in the same cycle as that last write.
  - COLOR: on pop, latch colour → FILL.
  - FILL: issues one write per cycle, no FIFO traffic, no stalls.
    - Last write → IDLE with pkt_done.
- Write latency: one cycle from pop (STREAM) or from the FILL issue cycle.
- Throughput: one pixel per clk when the FIFO is not empty.
- Empty FIFO: the FSM holds state and counters; fb_we=0 in the following cycle. No timeout.
- Address wrap: addr_q increments modulo FB_DEPTH (FB_DEPTH-1 → 0). FB_DEPTH need not be a power of two.
- A run longer than FB_DEPTH wraps repeatedly; this is legal and not an error.
- IDLE → next header is back-to-back: a new header can be popped in the cycle after the last payload pop. There are no bubble cycles between packets.
- Reset mid-packet: the FSM aborts to IDLE immediately. No further writes. Consumed words are lost; upstream is responsible for flushing.
- err is sticky. A faulty packet does not block subsequent packets.

Decomposition:
- Package rt_pkg contains:
  - pkt_type_t enum (NONE=00, PIXELS=01, FILL=10, RSVD=11).
  - fbw_state_t enum (IDLE, HDR_ADDR, COLOR, STREAM, FILL).
  - Header field position constants.
- Sub-module fb_addr_counter (parameters ADDR_W, FB_DEPTH), with ports: load, load_val, inc, addr. Implements the modulo-FB_DEPTH wrapping counter; reused by the future readback/scanout path.

Test Plan:
- Directed PIXELS packet, FIFO pre-filled with {01, count-1=3}, {addr=10}, then pixels A, B, C, D → writes to addresses 10, 11, 12, 13 with data A–D on 4 consecutive cycles. pkt_done coincides with the D write. busy returns to 0 the next cycle. err=0.
- FILL packet {10, count-1=4}, {addr=76798}, colour 0xFF00FF → 5 writes of 0xFF00FF to addresses 76798, 76799, 0, 1, 2. Exactly 3 pops total.
- PIXELS count 3, fifo_empty toggled every other cycle → exactly 3 writes, each one cycle after its pop. No fifo_re while empty. Addresses remain contiguous.
- Reserved header (type 11) followed by a valid PIXELS count-1=0 packet → err=1 after the first pop. The second packet's single pixel is still written. pkt_done pulses twice.
- Start address 80000 (≥ FB_DEPTH) in a PIXELS count-1=1 packet → both payload words are popped, fb_we stays 0, err=1, and the next packet proceeds normally.
- rst asserted during STREAM after 2 of 5 writes → outputs are 0 immediately (asynchronously). After deassertion, busy=0 and no further writes occur until a new header is popped.
